// File: rtl/mem_pkg.sv
// Shared sizes and types for the store read-modify-write path.
package mem_pkg;

  localparam int unsigned BLOCK_SIZE  = 128;
  localparam int unsigned OFFSET_BITS = 4;
  localparam int unsigned BLOCK_BYTES = BLOCK_SIZE / 8;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Store request captured at acceptance.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        funct3;
  } store_req_t;

endpackage

// File: rtl/store_conv.sv
// Combinational store merge: places sb/sh/sw bytes into an old block and flags illegal stores.
module store_conv
  import mem_pkg::*;
(
  input  logic [BLOCK_SIZE-1:0]  old_blk_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic [2:0]             funct3_i,
  input  logic [OFFSET_BITS-1:0] offset_i,
  output logic [BLOCK_SIZE-1:0]  merged_o,
  output logic                   illegal_o
);

  localparam int unsigned SHIFT_W = OFFSET_BITS + 3;

  logic [DATA_W-1:0]     lane_mask;
  logic [SHIFT_W-1:0]    shamt;
  logic [BLOCK_SIZE-1:0] blk_mask;
  logic [BLOCK_SIZE-1:0] blk_data;

  always_comb begin
    lane_mask = '0;
    illegal_o = 1'b0;
    case (store_op_e'(funct3_i))
      F3_SB: lane_mask = 32'h0000_00FF;
      F3_SH: begin
        lane_mask = 32'h0000_FFFF;
        illegal_o = offset_i[0];
      end
      F3_SW: begin
        lane_mask = 32'hFFFF_FFFF;
        illegal_o = |offset_i[1:0];
      end
      default: illegal_o = 1'b1;
    endcase
    // Natural alignment keeps every legal lane inside the block.
    shamt    = {offset_i, 3'b000};
    blk_mask = BLOCK_SIZE'(lane_mask) << shamt;
    blk_data = BLOCK_SIZE'(wdata_i & lane_mask) << shamt;
    merged_o = (old_blk_i & ~blk_mask) | blk_data;
  end

endmodule

// File: rtl/store_merge.sv
// Store read-modify-write controller: fetch block, merge store bytes, write block back.
module store_merge
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [2:0]            funct3_i,
  output logic                  rd_req_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic                  rd_valid_i,
  input  logic [BLOCK_SIZE-1:0] rd_data_i,
  output logic                  wr_req_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic [BLOCK_SIZE-1:0] wr_data_o,
  input  logic                  wr_ack_i,
  output logic                  done_o,
  output logic                  err_o
);

  state_e                state_q, state_d;
  store_req_t            req_q, req_d;
  logic [BLOCK_SIZE-1:0] merged_q, merged_d;

  logic                  req_ready_q, rd_req_q, wr_req_q, done_q, err_q;
  logic [ADDR_W-1:0]     rd_addr_q, wr_addr_q;
  logic [BLOCK_SIZE-1:0] wr_data_q;

  store_req_t            conv_req;
  logic [BLOCK_SIZE-1:0] conv_merged;
  logic                  conv_illegal;
  logic [ADDR_W-1:0]     blk_addr_d;

  // Legality is judged on live inputs in IDLE; merging uses the latched request.
  assign conv_req = (state_q == IDLE) ? store_req_t'{addr: addr_i, wdata: wdata_i, funct3: funct3_i}
                                      : req_q;

  store_conv u_conv (
    .old_blk_i (rd_data_i),
    .wdata_i   (conv_req.wdata),
    .funct3_i  (conv_req.funct3),
    .offset_i  (conv_req.addr[OFFSET_BITS-1:0]),
    .merged_o  (conv_merged),
    .illegal_o (conv_illegal)
  );

  // Next state and next request/merge registers.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    merged_d = merged_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_d   = conv_req;
          state_d = conv_illegal ? ERR : RD;
        end
      end
      RD: begin
        if (rd_valid_i) begin
          merged_d = conv_merged;
          state_d  = WR;
        end
      end
      WR: begin
        if (wr_ack_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign blk_addr_d = {req_d.addr[ADDR_W-1:OFFSET_BITS], OFFSET_BITS'(0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      merged_q    <= '0;
      req_ready_q <= 1'b1;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      merged_q    <= merged_d;
      // Outputs are registered decodes of the state being entered.
      req_ready_q <= (state_d == IDLE);
      rd_req_q    <= (state_d == RD);
      wr_req_q    <= (state_d == WR);
      done_q      <= (state_d == DONE);
      err_q       <= (state_d == ERR);
      rd_addr_q   <= (state_d == RD) ? blk_addr_d : '0;
      wr_addr_q   <= (state_d == WR) ? blk_addr_d : '0;
      wr_data_q   <= (state_d == WR) ? merged_d : '0;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rd_req_o    = rd_req_q;
  assign rd_addr_o   = rd_addr_q;
  assign wr_req_o    = wr_req_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge: sb/sh/sw merges, rejects, stalls, reset and back-to-back.
module tb_store_merge;
  import mem_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_W-1:0]     addr_i;
  logic [DATA_W-1:0]     wdata_i;
  logic [2:0]            funct3_i;
  logic                  rd_req_o;
  logic [ADDR_W-1:0]     rd_addr_o;
  logic                  rd_valid_i;
  logic [BLOCK_SIZE-1:0] rd_data_i;
  logic                  wr_req_o;
  logic [ADDR_W-1:0]     wr_addr_o;
  logic [BLOCK_SIZE-1:0] wr_data_o;
  logic                  wr_ack_i;
  logic                  done_o;
  logic                  err_o;

  int checks = 0;
  int errors = 0;
  logic [BLOCK_SIZE-1:0] blk;

  always #5 clk = ~clk;

  store_merge dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .funct3_i    (funct3_i),
    .rd_req_o    (rd_req_o),
    .rd_addr_o   (rd_addr_o),
    .rd_valid_i  (rd_valid_i),
    .rd_data_i   (rd_data_i),
    .wr_req_o    (wr_req_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_ack_i    (wr_ack_i),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BLOCK_SIZE-1:0] obs, input logic [BLOCK_SIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid_i = 1'b1;
    funct3_i    = f3;
    addr_i      = a;
    wdata_i     = d;
    tick();
    req_valid_i = 1'b0;
  endtask

  // Reject path: one-cycle err_o, no memory traffic, ready again two cycles after accept.
  task automatic expect_err(input string tag, input logic [2:0] f3, input logic [31:0] a);
    issue(f3, a, 32'h1234_5678);
    chk({tag, "_err"},   BLOCK_SIZE'(err_o), 1);
    chk({tag, "_rdreq"}, BLOCK_SIZE'(rd_req_o), 0);
    chk({tag, "_wrreq"}, BLOCK_SIZE'(wr_req_o), 0);
    chk({tag, "_rdy0"},  BLOCK_SIZE'(req_ready_o), 0);
    tick();
    chk({tag, "_err_end"}, BLOCK_SIZE'(err_o), 0);
    chk({tag, "_rdy1"},    BLOCK_SIZE'(req_ready_o), 1);
    chk({tag, "_wrreq2"},  BLOCK_SIZE'(wr_req_o | rd_req_o), 0);
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; addr_i = '0; wdata_i = '0; funct3_i = '0;
    rd_valid_i = 1'b0; rd_data_i = '0; wr_ack_i = 1'b0;
    tick(); tick();
    chk("rst_ready", BLOCK_SIZE'(req_ready_o), 1);
    chk("rst_rdreq", BLOCK_SIZE'(rd_req_o), 0);
    chk("rst_wrreq", BLOCK_SIZE'(wr_req_o), 0);
    chk("rst_done",  BLOCK_SIZE'(done_o | err_o), 0);
    chk("rst_wdata", wr_data_o, 0);
    rst = 1'b0;
    tick();

    // sb at 0x1003 over all-0x11 block, immediate handshakes.
    issue(3'b000, 32'h0000_1003, 32'hDEAD_BEEF);
    chk("sb_rdreq", BLOCK_SIZE'(rd_req_o), 1);
    chk("sb_rdaddr", BLOCK_SIZE'(rd_addr_o), 128'h1000);
    chk("sb_rdy", BLOCK_SIZE'(req_ready_o), 0);
    rd_valid_i = 1'b1; rd_data_i = {16{8'h11}};
    tick();
    rd_valid_i = 1'b0;
    chk("sb_wrreq", BLOCK_SIZE'(wr_req_o), 1);
    chk("sb_rdreq_off", BLOCK_SIZE'(rd_req_o), 0);
    chk("sb_wraddr", BLOCK_SIZE'(wr_addr_o), 128'h1000);
    chk("sb_wdata", wr_data_o, 128'h11111111_11111111_11111111_EF111111);
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk("sb_done", BLOCK_SIZE'(done_o), 1);
    chk("sb_wrreq_off", BLOCK_SIZE'(wr_req_o), 0);
    chk("sb_wdata_zero", wr_data_o, 0);
    tick();
    chk("sb_done_end", BLOCK_SIZE'(done_o), 0);
    chk("sb_rdy_back", BLOCK_SIZE'(req_ready_o), 1);

    // sh at 0x2006 over zero block.
    issue(3'b001, 32'h0000_2006, 32'h0000_1234);
    rd_valid_i = 1'b1; rd_data_i = '0;
    tick();
    rd_valid_i = 1'b0;
    chk("sh_wraddr", BLOCK_SIZE'(wr_addr_o), 128'h2000);
    chk("sh_wdata", wr_data_o, 128'h00000000_00000000_12340000_00000000);
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk("sh_done", BLOCK_SIZE'(done_o), 1);
    tick();

    // sw at 0x300C over all-ones block.
    issue(3'b010, 32'h0000_300C, 32'hCAFE_F00D);
    rd_valid_i = 1'b1; rd_data_i = '1;
    tick();
    rd_valid_i = 1'b0;
    chk("sw_wraddr", BLOCK_SIZE'(wr_addr_o), 128'h3000);
    chk("sw_wdata", wr_data_o, 128'hCAFEF00D_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk("sw_done", BLOCK_SIZE'(done_o), 1);
    tick();

    expect_err("sh_mis", 3'b001, 32'h0000_2007);
    expect_err("sw_mis", 3'b010, 32'h0000_3002);
    expect_err("f3_011", 3'b011, 32'h0000_4000);

    // Stalled handshakes with a spurious wr_ack_i during RD.
    issue(3'b010, 32'h0000_4008, 32'h0123_4567);
    rd_data_i = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    for (int i = 0; i < 5; i++) begin
      wr_ack_i = (i == 2);
      chk($sformatf("stall_rdreq_%0d", i), BLOCK_SIZE'(rd_req_o), 1);
      chk($sformatf("stall_rdaddr_%0d", i), BLOCK_SIZE'(rd_addr_o), 128'h4000);
      chk($sformatf("stall_wrreq_%0d", i), BLOCK_SIZE'(wr_req_o), 0);
      tick();
    end
    wr_ack_i = 1'b0;
    rd_valid_i = 1'b1;
    chk("stall_rd_last", BLOCK_SIZE'(rd_req_o), 1);
    tick();
    rd_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_wrreq_%0d", i), BLOCK_SIZE'(wr_req_o), 1);
      chk($sformatf("stall_wraddr_%0d", i), BLOCK_SIZE'(wr_addr_o), 128'h4000);
      chk($sformatf("stall_wdata_%0d", i), wr_data_o, 128'h00112233_01234567_8899AABB_CCDDEEFF);
      chk($sformatf("stall_nodone_%0d", i), BLOCK_SIZE'(done_o), 0);
      tick();
    end
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk("stall_done", BLOCK_SIZE'(done_o), 1);
    tick();

    // Reset while in WR abandons the write.
    issue(3'b000, 32'h0000_5001, 32'h0000_0077);
    rd_valid_i = 1'b1; rd_data_i = '0;
    tick();
    rd_valid_i = 1'b0;
    chk("rstwr_wrreq", BLOCK_SIZE'(wr_req_o), 1);
    rst = 1'b1; wr_ack_i = 1'b1;
    tick();
    rst = 1'b0; wr_ack_i = 1'b0;
    chk("rstwr_wrreq_off", BLOCK_SIZE'(wr_req_o), 0);
    chk("rstwr_ready", BLOCK_SIZE'(req_ready_o), 1);
    chk("rstwr_nodone", BLOCK_SIZE'(done_o | err_o), 0);
    chk("rstwr_wdata", wr_data_o, 0);
    tick();
    chk("rstwr_nodone2", BLOCK_SIZE'(done_o | err_o | rd_req_o), 0);

    // Back-to-back: request held high; second must wait for DONE.
    req_valid_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h0000_1000; wdata_i = 32'h0000_00AA;
    tick();
    addr_i = 32'h0000_1001; wdata_i = 32'h0000_00BB;
    chk("b2b_rdaddr1", BLOCK_SIZE'(rd_addr_o), 128'h1000);
    chk("b2b_rdy_rd", BLOCK_SIZE'(req_ready_o), 0);
    rd_valid_i = 1'b1; rd_data_i = '0;
    tick();
    rd_valid_i = 1'b0;
    blk = wr_data_o;
    chk("b2b_wdata1", wr_data_o, 128'h000000AA);
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk("b2b_done1", BLOCK_SIZE'(done_o), 1);
    chk("b2b_rdy_done", BLOCK_SIZE'(req_ready_o), 0);
    tick();
    chk("b2b_rdy_idle", BLOCK_SIZE'(req_ready_o), 1);
    tick();
    req_valid_i = 1'b0;
    chk("b2b_rdreq2", BLOCK_SIZE'(rd_req_o), 1);
    rd_valid_i = 1'b1; rd_data_i = blk;
    tick();
    rd_valid_i = 1'b0;
    chk("b2b_wdata2", wr_data_o, 128'h0000BBAA);
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    chk("b2b_done2", BLOCK_SIZE'(done_o), 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
